hazard3_ahbl_mtimer: RTL and testbench

- AHB-Lite slave implementing the RISC-V machine timer (mtime/mtimecmp) and machine software-interrupt register.
- Drives the hart's timer_irq and soft_irq inputs.
- Sits on the load/store bus fabric downstream of the CPU d-port, and upstream of the CPU interrupt inputs.
- Pauses counting while the hart is halted in Debug Mode, when enabled.

---
 rtl/hazard3_ahbl_mtimer.sv | 143 ++++++++++++++
 tb/tb_hazard3_ahbl_mtimer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard3_ahbl_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) and software-interrupt register on an AHB-Lite slave port.
// Zero-wait OKAY responses; illegal size/offset gets the two-cycle ERROR response.
module hazard3_ahbl_mtimer #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ahbls_hready,
  output logic              ahbls_hready_resp,
  output logic              ahbls_hresp,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic              ahbls_hsel,
  input  logic [2:0]        ahbls_hsize,
  input  logic [W_DATA-1:0] ahbls_hwdata,
  output logic [W_DATA-1:0] ahbls_hrdata,
  input  logic              dbg_halted,
  output logic              timer_irq,
  output logic              soft_irq
);

  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;
  typedef struct packed {
    logic       vld;
    logic       write;
    logic [2:0] idx;
  } dph_t;

  state_t state, state_nxt;
  dph_t   dph;

  logic aphase, aph_err;
  assign aphase  = ahbls_hsel && ahbls_htrans[1] && ahbls_hready;
  assign aph_err = (ahbls_hsize != 3'b010) || (ahbls_haddr[4:0] > 5'h18);

  // Fabric decodes the upper address bits; htrans[0] (SEQ) carries no meaning here.
  logic unused_bits;
  assign unused_bits = ^{ahbls_htrans[0], ahbls_haddr[W_ADDR-1:5], ahbls_haddr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dph   <= '0;
    end else begin
      state <= state_nxt;
      if (ahbls_hready) begin
        dph.vld   <= aphase && !aph_err;
        dph.write <= ahbls_hwrite;
        dph.idx   <= ahbls_haddr[4:2];
      end
    end
  end

  always_comb begin
    state_nxt         = state;
    ahbls_hready_resp = 1'b1;
    ahbls_hresp       = 1'b0;
    case (state)
      IDLE: if (aphase && aph_err) state_nxt = ERR1;
      ERR1: begin
        state_nxt         = ERR2;
        ahbls_hready_resp = 1'b0;
        ahbls_hresp       = 1'b1;
      end
      ERR2: begin
        // Bus is ready again here, so the next address phase may already be erroneous.
        state_nxt   = (aphase && aph_err) ? ERR1 : IDLE;
        ahbls_hresp = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic wen;
  logic wr_ctrl, wr_presc, wr_mtime, wr_mtimeh, wr_cmp, wr_cmph, wr_msip;
  assign wen       = dph.vld && dph.write;
  assign wr_ctrl   = wen && dph.idx == 3'd0;
  assign wr_presc  = wen && dph.idx == 3'd1;
  assign wr_mtime  = wen && dph.idx == 3'd2;
  assign wr_mtimeh = wen && dph.idx == 3'd3;
  assign wr_cmp    = wen && dph.idx == 3'd4;
  assign wr_cmph   = wen && dph.idx == 3'd5;
  assign wr_msip   = wen && dph.idx == 3'd6;

  logic        en, dbgpause, msip;
  logic [15:0] prescale, presc_ctr;
  logic [63:0] mtime, mtimecmp;
  logic        active, tick;

  assign active = en && !(dbgpause && dbg_halted);
  assign tick   = active && (presc_ctr == prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en        <= 1'b0;
      dbgpause  <= 1'b1;
      prescale  <= 16'h0;
      presc_ctr <= 16'h0;
      mtime     <= 64'h0;
      mtimecmp  <= '1;
      msip      <= 1'b0;
      timer_irq <= 1'b0;
      soft_irq  <= 1'b0;
    end else begin
      if (wr_ctrl)  {dbgpause, en} <= ahbls_hwdata[1:0];
      if (wr_presc) prescale       <= ahbls_hwdata[15:0];
      // Reprogramming restarts the prescale period from zero.
      if (wr_ctrl || wr_presc) presc_ctr <= 16'h0;
      else if (active)         presc_ctr <= tick ? 16'h0 : presc_ctr + 16'h1;
      // A bus write to either half swallows a coincident tick.
      if (wr_mtime || wr_mtimeh) begin
        if (wr_mtime)  mtime[31:0]  <= ahbls_hwdata[31:0];
        if (wr_mtimeh) mtime[63:32] <= ahbls_hwdata[31:0];
      end else if (tick) begin
        mtime <= mtime + 64'h1;
      end
      if (wr_cmp)  mtimecmp[31:0]  <= ahbls_hwdata[31:0];
      if (wr_cmph) mtimecmp[63:32] <= ahbls_hwdata[31:0];
      if (wr_msip) msip            <= ahbls_hwdata[0];
      timer_irq <= mtime >= mtimecmp;
      soft_irq  <= msip;
    end
  end

  always_comb begin
    ahbls_hrdata = '0;
    if (dph.vld && !dph.write) begin
      case (dph.idx)
        3'd0:    ahbls_hrdata = {30'h0, dbgpause, en};
        3'd1:    ahbls_hrdata = {16'h0, prescale};
        3'd2:    ahbls_hrdata = mtime[31:0];
        3'd3:    ahbls_hrdata = mtime[63:32];
        3'd4:    ahbls_hrdata = mtimecmp[31:0];
        3'd5:    ahbls_hrdata = mtimecmp[63:32];
        3'd6:    ahbls_hrdata = {31'h0, msip};
        default: ahbls_hrdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard3_ahbl_mtimer.sv
// Randomised scoreboard bench for hazard3_ahbl_mtimer. mtime is modelled as
// base + ticks, where ticks = active_cycles / (PRESCALE+1) since the last prescaler restart.
module tb_hazard3_ahbl_mtimer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hready_resp, hresp, hwrite, hsel, dbg_halted;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        timer_irq, soft_irq;

  always #5 clk = ~clk;

  hazard3_ahbl_mtimer #(.W_ADDR(32), .W_DATA(32)) dut (
    .clk(clk), .rst(rst),
    .ahbls_hready(hready_resp), .ahbls_hready_resp(hready_resp), .ahbls_hresp(hresp),
    .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(htrans), .ahbls_hsel(hsel),
    .ahbls_hsize(hsize), .ahbls_hwdata(hwdata), .ahbls_hrdata(hrdata),
    .dbg_halted(dbg_halted), .timer_irq(timer_irq), .soft_irq(soft_irq)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_en, m_dp, m_msip, m_irq, m_soft;
  logic [15:0] m_pre;
  logic [63:0] m_base, m_cmp;
  int unsigned m_act, m_anchor;
  bit          mw_vld;
  logic [2:0]  mw_idx;
  logic [31:0] mw_data;

  function automatic logic [63:0] m_mtime();
    int unsigned d;
    d = 32'(m_pre) + 1;
    return m_base + 64'(m_act / d) - 64'(m_anchor / d);
  endfunction

  function automatic logic [31:0] rd_model(input logic [2:0] i);
    logic [63:0] t;
    t = m_mtime();
    case (i)
      3'd0: return {30'h0, m_dp, m_en};
      3'd1: return {16'h0, m_pre};
      3'd2: return t[31:0];
      3'd3: return t[63:32];
      3'd4: return m_cmp[31:0];
      3'd5: return m_cmp[63:32];
      3'd6: return {31'h0, m_msip};
      default: return 32'h0;
    endcase
  endfunction

  logic [63:0] m_old;
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_en = 0; m_dp = 1; m_msip = 0; m_irq = 0; m_soft = 0;
      m_pre = 16'h0; m_base = 64'h0; m_cmp = '1; m_act = 0; m_anchor = 0;
    end else begin
      m_old  = m_mtime();
      m_irq  = m_old >= m_cmp;
      m_soft = m_msip;
      if (m_en && !(m_dp && dbg_halted)) m_act++;
      if (mw_vld) begin
        case (mw_idx)
          3'd0: begin
            m_base = m_mtime(); m_act = 0; m_anchor = 0;
            m_en = mw_data[0]; m_dp = mw_data[1];
          end
          3'd1: begin
            m_base = m_mtime(); m_act = 0; m_anchor = 0;
            m_pre = mw_data[15:0];
          end
          3'd2: begin m_base = {m_old[63:32], mw_data}; m_anchor = m_act; end
          3'd3: begin m_base = {mw_data, m_old[31:0]}; m_anchor = m_act; end
          3'd4: m_cmp[31:0]  = mw_data;
          3'd5: m_cmp[63:32] = mw_data;
          3'd6: m_msip = mw_data[0];
          default: ;
        endcase
      end
    end
  end

  // ---------------- scoreboard + monitor ----------------
  typedef struct { bit err; logic [31:0] data; } exp_t;
  exp_t sb[$];
  exp_t e;
  bit   prev_acc, in_err2, cur_acc;

  initial begin
    prev_acc = 0; in_err2 = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_acc = 0; in_err2 = 0;
      end else begin
        cur_acc = hsel && htrans[1] && hready_resp;
        chk("timer_irq", timer_irq, m_irq);
        chk("soft_irq", soft_irq, m_soft);
        if (in_err2) begin
          chk("err2_ready", hready_resp, 1);
          chk("err2_resp", hresp, 1);
          in_err2 = 0;
        end else if (prev_acc) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_underflow: data phase with no expected entry at %0t", $time);
          end else begin
            e = sb.pop_front();
            if (e.err) begin
              chk("err1_ready", hready_resp, 0);
              chk("err1_resp", hresp, 1);
              in_err2 = 1;
            end else begin
              chk("okay_ready", hready_resp, 1);
              chk("okay_resp", hresp, 0);
              chk("hrdata", hrdata, e.data);
            end
          end
        end else begin
          chk("idle_ready", hready_resp, 1);
          chk("idle_resp", hresp, 0);
          chk("idle_hrdata", hrdata, 0);
        end
        prev_acc = cur_acc;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic xfer(input bit wr, input logic [4:0] addr, input logic [2:0] size,
                      input logic [31:0] wd);
    bit err;
    err = (size != 3'd2) || (addr > 5'h18);
    hsel = 1; htrans = 2'b10; hwrite = wr; haddr = {27'h0, addr}; hsize = size;
    cyc();
    hsel = 0; htrans = 2'b00;
    if (err) begin
      sb.push_back('{1'b1, 32'h0});
      cyc();
    end else begin
      hwdata = wd;
      if (wr) begin
        mw_vld = 1; mw_idx = addr[4:2]; mw_data = wd;
        sb.push_back('{1'b0, 32'h0});
      end else begin
        sb.push_back('{1'b0, rd_model(addr[4:2])});
      end
      cyc();
      mw_vld = 0;
    end
  endtask

  task automatic rd(input logic [4:0] a);
    xfer(0, a, 3'd2, 32'h0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    xfer(1, a, 3'd2, d);
  endtask

  int          r, idx;
  logic [2:0]  sz;
  logic [31:0] d;

  initial begin
    hsel = 0; htrans = 0; hwrite = 0; haddr = 0; hsize = 3'd2; hwdata = 0;
    dbg_halted = 0; mw_vld = 0; mw_idx = 0; mw_data = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    cyc();
    for (int i = 0; i < 7; i++) rd(5'(i * 4));

    // prescaled and full-rate counting
    wr(5'h04, 32'd3); wr(5'h00, 32'd1); idle(40); rd(5'h08);
    wr(5'h04, 32'd0); idle(10); rd(5'h08); rd(5'h0c);

    // 64-bit rollover, then compare threshold
    wr(5'h0c, 32'hffffffff); wr(5'h08, 32'hfffffffe); rd(5'h08); rd(5'h0c);
    idle(3); rd(5'h08); rd(5'h0c);
    wr(5'h10, 32'h10); wr(5'h14, 32'h0); idle(20); rd(5'h08);
    wr(5'h14, 32'h1); idle(3);

    // debug pause
    wr(5'h00, 32'd3); dbg_halted = 1; idle(20); rd(5'h08);
    dbg_halted = 0; idle(5); rd(5'h08);
    wr(5'h00, 32'd1); dbg_halted = 1; idle(10); rd(5'h08); dbg_halted = 0;

    // error responses, including a read issued in ERR2
    xfer(1, 5'h08, 3'd0, 32'h1234);
    rd(5'h08);
    rd(5'h1c);
    rd(5'h00);
    xfer(1, 5'h1c, 3'd2, 32'h5);
    idle(2);

    // software interrupt
    wr(5'h18, 32'd1); idle(2); wr(5'h18, 32'd0); idle(2);

    // randomised traffic
    for (int n = 0; n < 400; n++) begin
      r   = $urandom_range(0, 9);
      idx = $urandom_range(0, 6);
      case (r)
        0, 1, 2: rd(5'(idx * 4));
        3, 4: begin
          case (idx)
            0:       d = $urandom_range(0, 3);
            1:       d = $urandom_range(0, 5);
            2, 4:    d = $urandom_range(0, 1) ? rd_model(3'd2) + $urandom_range(0, 30) : $urandom;
            3, 5:    d = $urandom_range(0, 1) ? rd_model(3'd3) : $urandom;
            default: d = $urandom_range(0, 1);
          endcase
          wr(5'(idx * 4), d);
        end
        5: begin
          if ($urandom_range(0, 1) != 0) begin
            sz = 3'($urandom_range(0, 6));
            if (sz >= 3'd2) sz = sz + 3'd1;
            xfer($urandom_range(0, 1) != 0, 5'(idx * 4), sz, $urandom);
          end else begin
            xfer($urandom_range(0, 1) != 0, 5'h1c, 3'd2, $urandom);
          end
        end
        6: idle($urandom_range(1, 8));
        7: dbg_halted = ($urandom_range(0, 1) != 0);
        default: rd(5'h08);
      endcase
    end
    dbg_halted = 0;
    idle(3);
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
